// File: rtl/tl_ul_responder.sv
// TL-UL target terminating Get/PutFullData/PutPartialData into a 64-bit scratch RAM; optional counters under TL_RESP_STATS_EN.
// Latency: d_valid is registered on the A handshake edge; one request in flight, peak one transaction per 2 cycles.
// Backpressure: a_ready drops while a response is pending; d_* outputs hold until d_ready.
module tl_ul_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h7000_0000,
    parameter int          DEPTH_LOG2   = 6,
    parameter int          SOURCE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [2:0]              a_param,
    input  logic [2:0]              a_size,
    input  logic [SOURCE_WIDTH-1:0] a_source,
    input  logic [31:0]             a_address,
    input  logic [7:0]              a_mask,
    input  logic [63:0]             a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [1:0]              d_param,
    output logic [2:0]              d_size,
    output logic [SOURCE_WIDTH-1:0] d_source,
    output logic                    d_sink,
    output logic                    d_denied,
    output logic [63:0]             d_data,
    output logic                    d_corrupt,
    output logic [15:0]             stat_rd,
    output logic [15:0]             stat_wr,
    output logic [15:0]             stat_err
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam int          WORDS = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN  = 32'd8 << DEPTH_LOG2;

    state_t                state;
    logic [63:0]           mem [WORDS];
    logic [31:0]           off;
    logic [31:0]           alignMask;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic                  inRange, aligned, opKnown, isGet, legal, accept;
    logic                  unusedParam;

    assign unusedParam = ^a_param;

    assign off       = a_address - BASE_ADDR;
    assign alignMask = (32'd1 << a_size) - 32'd1;
    assign wordIdx   = off[DEPTH_LOG2+2:3];
    assign inRange   = (a_address >= BASE_ADDR) && (off < SPAN);
    assign aligned   = (a_address & alignMask) == 32'd0;
    assign isGet     = a_opcode == 3'd4;
    assign opKnown   = isGet || (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign legal     = inRange && aligned && (a_size <= 3'd3) && opKnown;

    // Gating with reset_n keeps a_ready low for the whole reset and high right after release.
    assign a_ready = reset_n && (state == IDLE);
    assign accept  = a_valid && a_ready;

    assign d_param   = 2'b00;
    assign d_sink    = 1'b0;
    assign d_corrupt = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            d_valid  <= 1'b0;
            d_opcode <= 3'd0;
            d_size   <= 3'd0;
            d_source <= '0;
            d_denied <= 1'b0;
            d_data   <= 64'd0;
        end else if (state == IDLE) begin
            if (accept) begin
                state    <= RESP;
                d_valid  <= 1'b1;
                d_opcode <= isGet ? 3'd1 : 3'd0;
                d_size   <= a_size;
                d_source <= a_source;
                d_denied <= !legal;
                d_data   <= (legal && isGet) ? mem[wordIdx] : 64'd0;
            end
        end else if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
        end
    end

    // The write lands on the accept edge, so any later Get sees it.
    always_ff @(posedge clk) begin
        if (accept && legal && !isGet) begin
            for (int b = 0; b < 8; b++) begin
                if (a_mask[b]) begin
                    mem[wordIdx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

`ifdef TL_RESP_STATS_EN
    logic [15:0] statRd, statWr, statErr;
    logic        dFire;

    assign dFire = d_valid && d_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            statRd  <= 16'd0;
            statWr  <= 16'd0;
            statErr <= 16'd0;
        end else if (dFire) begin
            if (d_denied) begin
                statErr <= (statErr == 16'hFFFF) ? statErr : statErr + 16'd1;
            end else if (d_opcode == 3'd1) begin
                statRd <= (statRd == 16'hFFFF) ? statRd : statRd + 16'd1;
            end else begin
                statWr <= (statWr == 16'hFFFF) ? statWr : statWr + 16'd1;
            end
        end
    end

    assign stat_rd  = statRd;
    assign stat_wr  = statWr;
    assign stat_err = statErr;
`else
    assign stat_rd  = 16'd0;
    assign stat_wr  = 16'd0;
    assign stat_err = 16'd0;
`endif

endmodule

// File: tb/tb_tl_ul_responder.sv
// Directed bench for tl_ul_responder: put/get, partial writes, error decode, backpressure, reset mid-response, counters.
module tb_tl_ul_responder;

    logic        clk;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_err;

    int tests  = 0;
    int failed = 0;

`ifdef TL_RESP_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    tl_ul_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt),
        .stat_rd   (stat_rd),
        .stat_wr   (stat_wr),
        .stat_err  (stat_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns #1 after the accepting edge.
    task automatic sendReq(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                           input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
        bit done;
        done      = 1'b0;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        a_valid = 1'b0;
        check("accept", {63'd0, done}, 64'd1);
    endtask

    // Checks the pending response and completes it (d_ready assumed high).
    task automatic expectResp(input string tag, input logic [2:0] op, input logic [3:0] src,
                              input logic denied, input logic [63:0] data, input logic [2:0] size);
        @(negedge clk);
        check({tag, ".valid"},  {63'd0, d_valid},  64'd1);
        check({tag, ".opcode"}, {61'd0, d_opcode}, {61'd0, op});
        check({tag, ".source"}, {60'd0, d_source}, {60'd0, src});
        check({tag, ".denied"}, {63'd0, d_denied}, {63'd0, denied});
        check({tag, ".data"},   d_data,            data);
        check({tag, ".size"},   {61'd0, d_size},   {61'd0, size});
        @(posedge clk);
        #1;
    endtask

    task automatic checkStats(input string tag, input int rd, input int wr, input int err);
        check({tag, ".stat_rd"},  {48'd0, stat_rd},  64'(STATS_ON * rd));
        check({tag, ".stat_wr"},  {48'd0, stat_wr},  64'(STATS_ON * wr));
        check({tag, ".stat_err"}, {48'd0, stat_err}, 64'(STATS_ON * err));
    endtask

    initial begin
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 3'd0;
        a_source  = 4'd0;
        a_address = 32'd0;
        a_mask    = 8'd0;
        a_data    = 64'd0;
        d_ready   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.a_ready", {63'd0, a_ready}, 64'd0);
        check("rst.d_valid", {63'd0, d_valid}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst.a_ready",  {63'd0, a_ready},  64'd1);
        check("post_rst.d_valid",  {63'd0, d_valid},  64'd0);
        check("post_rst.d_opcode", {61'd0, d_opcode}, 64'd0);
        check("post_rst.d_size",   {61'd0, d_size},   64'd0);
        check("post_rst.d_source", {60'd0, d_source}, 64'd0);
        check("post_rst.d_denied", {63'd0, d_denied}, 64'd0);
        check("post_rst.d_data",   d_data,            64'd0);
        check("post_rst.consts",   {60'd0, d_param, d_sink, d_corrupt}, 64'd0);
        checkStats("post_rst", 0, 0, 0);

        sendReq(3'd0, 3'd3, 4'd5, 32'h7000_0008, 8'hFF, 64'h1122_3344_5566_7788);
        expectResp("put_full", 3'd0, 4'd5, 1'b0, 64'd0, 3'd3);
        sendReq(3'd4, 3'd3, 4'd6, 32'h7000_0008, 8'h00, 64'd0);
        expectResp("get_full", 3'd1, 4'd6, 1'b0, 64'h1122_3344_5566_7788, 3'd3);

        sendReq(3'd1, 3'd3, 4'd2, 32'h7000_0008, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
        expectResp("put_part", 3'd0, 4'd2, 1'b0, 64'd0, 3'd3);
        sendReq(3'd4, 3'd3, 4'd3, 32'h7000_0008, 8'hFF, 64'd0);
        expectResp("get_part", 3'd1, 4'd3, 1'b0, 64'h1122_3344_BBBB_BBBB, 3'd3);

        sendReq(3'd4, 3'd3, 4'd7, 32'h7000_0200, 8'hFF, 64'd0);
        expectResp("err_range", 3'd1, 4'd7, 1'b1, 64'd0, 3'd3);
        sendReq(3'd0, 3'd3, 4'd8, 32'h7000_0004, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        expectResp("err_align", 3'd0, 4'd8, 1'b1, 64'd0, 3'd3);
        sendReq(3'd2, 3'd3, 4'd1, 32'h7000_0008, 8'hFF, 64'h0);
        expectResp("err_opcode", 3'd0, 4'd1, 1'b1, 64'd0, 3'd3);
        sendReq(3'd4, 3'd3, 4'd4, 32'h7000_0008, 8'hFF, 64'd0);
        expectResp("get_after_err", 3'd1, 4'd4, 1'b0, 64'h1122_3344_BBBB_BBBB, 3'd3);

        // Backpressure, with a competing Put presented while the response is pending.
        d_ready = 1'b0;
        sendReq(3'd4, 3'd3, 4'd9, 32'h7000_0008, 8'h00, 64'd0);
        a_opcode  = 3'd0;
        a_address = 32'h7000_0008;
        a_mask    = 8'hFF;
        a_data    = 64'd0;
        a_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.d_valid",  {63'd0, d_valid},  64'd1);
            check("bp.d_data",   d_data,            64'h1122_3344_BBBB_BBBB);
            check("bp.d_opcode", {61'd0, d_opcode}, 64'd1);
            check("bp.d_source", {60'd0, d_source}, 64'd9);
            check("bp.a_ready",  {63'd0, a_ready},  64'd0);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        d_ready = 1'b1;
        @(negedge clk);
        check("bp_release.d_valid", {63'd0, d_valid}, 64'd1);
        check("bp_release.a_ready", {63'd0, a_ready}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_done.a_ready", {63'd0, a_ready}, 64'd1);
        check("bp_done.d_valid", {63'd0, d_valid}, 64'd0);

        sendReq(3'd4, 3'd3, 4'd10, 32'h7000_0008, 8'hFF, 64'd0);
        expectResp("get_after_bp", 3'd1, 4'd10, 1'b0, 64'h1122_3344_BBBB_BBBB, 3'd3);
        checkStats("mid", 5, 2, 3);

        // Reset while a Put response is pending; the write itself must survive.
        d_ready = 1'b0;
        sendReq(3'd0, 3'd3, 4'd11, 32'h7000_0010, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_resp.a_ready_now", {63'd0, a_ready}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_resp.d_valid", {63'd0, d_valid}, 64'd0);
        check("rst_resp.a_ready", {63'd0, a_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
        @(negedge clk);
        check("rst_resp_rel.a_ready", {63'd0, a_ready}, 64'd1);
        check("rst_resp_rel.d_valid", {63'd0, d_valid}, 64'd0);
        checkStats("rst_resp_rel", 0, 0, 0);
        sendReq(3'd4, 3'd3, 4'd12, 32'h7000_0010, 8'hFF, 64'd0);
        expectResp("get_after_rst", 3'd1, 4'd12, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 3'd3);

        // Last word of the window is in range; one word below the base is not.
        sendReq(3'd0, 3'd3, 4'd13, 32'h7000_01F8, 8'hFF, 64'h0123_4567_89AB_CDEF);
        expectResp("put_last", 3'd0, 4'd13, 1'b0, 64'd0, 3'd3);
        sendReq(3'd4, 3'd3, 4'd14, 32'h7000_01F8, 8'hFF, 64'd0);
        expectResp("get_last", 3'd1, 4'd14, 1'b0, 64'h0123_4567_89AB_CDEF, 3'd3);
        sendReq(3'd4, 3'd3, 4'd15, 32'h6FFF_FFF8, 8'hFF, 64'd0);
        expectResp("err_below", 3'd1, 4'd15, 1'b1, 64'd0, 3'd3);
        checkStats("final", 2, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
